// File: rtl/stq_cam_multi.sv
// Multi-port store-queue address CAM with per-entry valid bits, a registered
// circular-priority nearest-match search per port, and a registered occupancy count.
module stq_cam_multi #(
  parameter int DEPTH    = 16,
  parameter int INDEX    = 4,
  parameter int WIDTH    = 8,
  parameter int RPORT    = 2,
  parameter int WPORT    = 2,
  parameter int FUNCTION = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WPORT-1:0]       we_i,
  input  logic [WPORT*INDEX-1:0] addrWr_i,
  input  logic [WPORT*WIDTH-1:0] dataWr_i,
  input  logic                   clr_i,
  input  logic [DEPTH-1:0]       clrVect_i,
  input  logic                   flush_i,
  input  logic [RPORT-1:0]       srch_i,
  input  logic [RPORT*WIDTH-1:0] tag_i,
  input  logic [RPORT*INDEX-1:0] start_i,
  output logic [RPORT*DEPTH-1:0] vect_o,
  output logic [RPORT-1:0]       hit_o,
  output logic [RPORT*INDEX-1:0] idx_o,
  output logic [INDEX:0]         validCnt_o
);

  logic [WIDTH-1:0]       ram [DEPTH];
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [RPORT*DEPTH-1:0] vect_q, vect_d;
  logic [RPORT-1:0]       hit_q, hit_d;
  logic [RPORT*INDEX-1:0] idx_q, idx_d;
  logic [INDEX:0]         cnt_q, cnt_d;

  // Applied lowest priority first so later assignments override: clear < write < flush.
  always_comb begin : valid_next
    valid_d = valid_q;
    if (clr_i) valid_d = valid_d & ~clrVect_i;
    for (int w = 0; w < WPORT; w++) begin
      if (we_i[w]) valid_d[addrWr_i[w*INDEX +: INDEX]] = 1'b1;
    end
    if (flush_i) valid_d = '0;
  end

  always_comb begin : count_next
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{INDEX{1'b0}}, valid_d[i]};
    end
  end

  // Searches use pre-update state; scan runs downward from start, wrapping modulo DEPTH.
  always_comb begin : search_logic
    logic [DEPTH-1:0] match;
    logic [WIDTH-1:0] t;
    logic [INDEX-1:0] s, pos;
    logic             found;
    vect_d = '0;
    hit_d  = '0;
    idx_d  = '0;
    match  = '0;
    t      = '0;
    s      = '0;
    pos    = '0;
    found  = 1'b0;
    for (int p = 0; p < RPORT; p++) begin
      t     = tag_i[p*WIDTH +: WIDTH];
      s     = start_i[p*INDEX +: INDEX];
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (FUNCTION == 0) match[i] = valid_q[i] && (ram[i] == t);
        else               match[i] = valid_q[i] && (ram[i] > t);
      end
      if (!srch_i[p]) match = '0;
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        pos = s - k[INDEX-1:0];
        if (!found && match[pos]) begin
          found                   = 1'b1;
          idx_d[p*INDEX +: INDEX] = pos;
        end
      end
      vect_d[p*DEPTH +: DEPTH] = match;
      hit_d[p]                 = |match;
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (reset) begin
      valid_q <= '0;
      vect_q  <= '0;
      hit_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      vect_q  <= vect_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // No reset on storage; later write ports override earlier ones on the same index.
  always_ff @(posedge clk) begin : ram_write
    if (!reset && !flush_i) begin
      for (int w = 0; w < WPORT; w++) begin
        if (we_i[w]) ram[addrWr_i[w*INDEX +: INDEX]] <= dataWr_i[w*WIDTH +: WIDTH];
      end
    end
  end

  assign vect_o     = vect_q;
  assign hit_o      = hit_q;
  assign idx_o      = idx_q;
  assign validCnt_o = cnt_q;

endmodule

// File: tb/tb_stq_cam_multi.sv
// Directed self-checking bench for stq_cam_multi: an equality instance and a
// greater-than instance, with hand-computed expected values.
module tb_stq_cam_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  we;
  logic [7:0]  addr_wr;
  logic [15:0] data_wr;
  logic        clr;
  logic [15:0] clr_vect;
  logic        flush;
  logic [1:0]  srch;
  logic [15:0] tag;
  logic [7:0]  start;
  logic [31:0] vect;
  logic [1:0]  hit;
  logic [7:0]  idx;
  logic [4:0]  cnt;

  logic        f_reset;
  logic [1:0]  f_we;
  logic [7:0]  f_addr_wr;
  logic [15:0] f_data_wr;
  logic [1:0]  f_srch;
  logic [15:0] f_tag;
  logic [7:0]  f_start;
  logic [31:0] f_vect;
  logic [1:0]  f_hit;
  logic [7:0]  f_idx;
  logic [4:0]  f_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stq_cam_multi #(.FUNCTION(0)) u_eq (
    .clk(clk), .reset(reset), .we_i(we), .addrWr_i(addr_wr), .dataWr_i(data_wr),
    .clr_i(clr), .clrVect_i(clr_vect), .flush_i(flush), .srch_i(srch), .tag_i(tag),
    .start_i(start), .vect_o(vect), .hit_o(hit), .idx_o(idx), .validCnt_o(cnt)
  );

  stq_cam_multi #(.FUNCTION(1)) u_gt (
    .clk(clk), .reset(f_reset), .we_i(f_we), .addrWr_i(f_addr_wr), .dataWr_i(f_data_wr),
    .clr_i(1'b0), .clrVect_i(16'h0), .flush_i(1'b0), .srch_i(f_srch), .tag_i(f_tag),
    .start_i(f_start), .vect_o(f_vect), .hit_o(f_hit), .idx_o(f_idx), .validCnt_o(f_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; we = '0; addr_wr = '0; data_wr = '0; clr = 1'b0; clr_vect = '0;
    flush = 1'b0; srch = '0; tag = '0; start = '0;
    f_reset = 1'b0; f_we = '0; f_addr_wr = '0; f_data_wr = '0; f_srch = '0;
    f_tag = '0; f_start = '0;
  endtask

  task automatic wr(input int w, input logic [3:0] a, input logic [7:0] d);
    we[w] = 1'b1;
    addr_wr[w*4 +: 4] = a;
    data_wr[w*8 +: 8] = d;
  endtask

  task automatic sr(input int p, input logic [7:0] t, input logic [3:0] s);
    srch[p] = 1'b1;
    tag[p*8 +: 8] = t;
    start[p*4 +: 4] = s;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  initial begin
    idle();
    // Reset, then a search on an empty CAM.
    reset = 1'b1; f_reset = 1'b1;
    tick();
    idle();
    sr(0, 8'h00, 4'd0); sr(1, 8'h00, 4'd0);
    tick();
    chk("empty_vect", vect, 32'h0);
    chk("empty_hit", {30'h0, hit}, 32'h0);
    chk("empty_idx", {24'h0, idx}, 32'h0);
    chk("empty_cnt", {27'h0, cnt}, 32'd0);

    // Entries 3 and 9 hold 0x5A.
    idle(); wr(0, 4'd3, 8'h5A); wr(1, 4'd9, 8'h5A);
    tick();
    chk("wr2_cnt", {27'h0, cnt}, 32'd2);
    idle(); sr(0, 8'h5A, 4'd5); sr(1, 8'h5A, 4'd10);
    tick();
    chk("s1_vect", vect, 32'h0208_0208);
    chk("s1_hit", {30'h0, hit}, 32'h3);
    chk("s1_idx", {24'h0, idx}, 32'h93);

    // Clear 3, add 12: start 5 must wrap to 12 before reaching 9.
    idle(); wr(0, 4'd12, 8'h5A); clr = 1'b1; clr_vect = 16'h0008;
    tick();
    chk("wrap_cnt", {27'h0, cnt}, 32'd2);
    idle(); sr(0, 8'h5A, 4'd5); sr(1, 8'h5A, 4'd11);
    tick();
    chk("wrap_vect", vect, 32'h1200_1200);
    chk("wrap_idx", {24'h0, idx}, 32'h9C);

    // Two writes plus a clear on entry 4; same-cycle search must miss.
    idle(); wr(0, 4'd4, 8'h11); wr(1, 4'd4, 8'h22); clr = 1'b1; clr_vect = 16'h0010;
    sr(0, 8'h22, 4'd4);
    tick();
    chk("same_cyc_hit", {30'h0, hit}, 32'h0);
    chk("same_cyc_vect", vect, 32'h0);
    chk("same_cyc_cnt", {27'h0, cnt}, 32'd3);
    idle(); sr(0, 8'h22, 4'd4); sr(1, 8'h11, 4'd4);
    tick();
    chk("next_cyc_hit", {30'h0, hit}, 32'h1);
    chk("next_cyc_vect", vect, 32'h0000_0010);
    chk("next_cyc_idx", {24'h0, idx}, 32'h04);

    // Disabled port 1 registers zeros.
    idle(); sr(0, 8'h5A, 4'd15); tag[15:8] = 8'h5A; start[7:4] = 4'd15;
    tick();
    chk("dis_vect", vect, 32'h0000_1200);
    chk("dis_hit", {30'h0, hit}, 32'h1);
    chk("dis_idx", {24'h0, idx}, 32'h0C);

    // Overwriting a valid entry keeps the count.
    idle(); wr(0, 4'd12, 8'h77);
    tick();
    chk("ovw_cnt", {27'h0, cnt}, 32'd3);
    idle(); sr(0, 8'h77, 4'd0);
    tick();
    chk("ovw_vect", vect, 32'h0000_1000);
    chk("ovw_idx", {24'h0, idx}, 32'h0C);

    // Fill all entries with data equal to the index.
    for (int i = 0; i < 8; i++) begin
      idle(); wr(0, 4'(2*i), 8'(2*i)); wr(1, 4'(2*i+1), 8'(2*i+1));
      tick();
    end
    chk("full_cnt", {27'h0, cnt}, 32'd16);
    idle(); sr(0, 8'h0F, 4'd0);
    tick();
    chk("full_vect", vect, 32'h0000_8000);
    chk("full_idx", {24'h0, idx}, 32'h0F);

    // Flush beats a same-cycle write; the same-cycle search still sees old state.
    idle(); flush = 1'b1; wr(0, 4'd0, 8'h00); sr(0, 8'h00, 4'd0);
    tick();
    chk("flush_cnt", {27'h0, cnt}, 32'd0);
    chk("flush_samecyc_vect", vect, 32'h0000_0001);
    idle(); sr(0, 8'h00, 4'd0);
    tick();
    chk("post_flush_hit", {30'h0, hit}, 32'h0);
    chk("post_flush_vect", vect, 32'h0);

    // Reset mid-stream clears everything at the next edge.
    idle(); wr(0, 4'd1, 8'h01); wr(1, 4'd2, 8'h02);
    tick();
    idle(); sr(0, 8'h01, 4'd3);
    tick();
    chk("pre_rst_idx", {24'h0, idx}, 32'h01);
    chk("pre_rst_cnt", {27'h0, cnt}, 32'd2);
    idle(); reset = 1'b1; sr(0, 8'h02, 4'd3); sr(1, 8'h01, 4'd3); wr(0, 4'd5, 8'h05);
    tick();
    chk("rst_vect", vect, 32'h0);
    chk("rst_hit", {30'h0, hit}, 32'h0);
    chk("rst_idx", {24'h0, idx}, 32'h0);
    chk("rst_cnt", {27'h0, cnt}, 32'd0);
    idle(); sr(0, 8'h02, 4'd3);
    tick();
    chk("post_rst_hit", {30'h0, hit}, 32'h0);

    // Greater-than instance: 0x10..0x40 in entries 0..3, tag 0x25.
    idle();
    f_we = 2'b11; f_addr_wr = {4'd1, 4'd0}; f_data_wr = {8'h20, 8'h10};
    tick();
    idle();
    f_we = 2'b11; f_addr_wr = {4'd3, 4'd2}; f_data_wr = {8'h40, 8'h30};
    tick();
    idle();
    f_srch = 2'b11; f_tag = {8'h25, 8'h25}; f_start = {4'd2, 4'd3};
    tick();
    chk("gt_vect", f_vect, 32'h000C_000C);
    chk("gt_idx", {24'h0, f_idx}, 32'h23);
    chk("gt_hit", {30'h0, f_hit}, 32'h3);
    chk("gt_cnt", {27'h0, f_cnt}, 32'd4);

    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stq_cam_multi.md
# stq_cam_multi

Parametrised multi-port store-queue address CAM that tracks a valid bit per entry. It serves the LSU's load-to-store disambiguation and forwarding search. Each search port returns a registered match vector and the index of the nearest matching older entry, found by a circular priority scan from a caller-supplied start index. Entries are allocated through write ports and retired by a bulk clear mask or a full flush. A registered occupancy count is provided.

## Interface
- DEPTH, 16, number of entries.
- INDEX, 4, entry index width (log2 DEPTH).
- WIDTH, 8, tag/data width.
- RPORT, 2, number of search ports.
- WPORT, 2, number of write ports.
- FUNCTION, 0, compare mode: 0 = entry equal to tag, 1 = entry greater than tag (unsigned).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we_i  in  WPORT  write enable per write port.
- addrWr_i  in  WPORT*INDEX  write index. Port w occupies slice [w*INDEX +: INDEX].
- dataWr_i  in  WPORT*WIDTH  write data. Slice per port.
- clr_i  in  1  apply clrVect_i this cycle.
- clrVect_i  in  DEPTH  entries to invalidate.
- flush_i  in  1  invalidate all entries.
- srch_i  in  RPORT  search enable per port.
- tag_i  in  RPORT*WIDTH  search tag. Slice per port.
- start_i  in  RPORT*INDEX  scan start index. Slice per port.
- vect_o  out  RPORT*DEPTH  registered match vector.
- hit_o  out  RPORT  registered: any bit of the port's vector set.
- idx_o  out  RPORT*INDEX  registered nearest-match index.
- validCnt_o  out  INDEX+1  registered count of valid entries.

## Operation
- State: ram[DEPTH] of WIDTH bits, with no reset. valid[DEPTH] bits.
- Entry match for port p: valid[i] && (FUNCTION==0 ? ram[i]==tag : ram[i]>tag).
- Searches see ram and valid as they stand at the start of the cycle (read-before-write). A same-cycle write, clear or flush does not affect that cycle's search.
- Scan order from start s: s, s-1, …, 0, DEPTH-1, …, s+1. Index arithmetic is modulo DEPTH, and DEPTH is a power of two. idx_o is the first matching entry in this order.
- A port with no match produces vect 0, hit 0, idx 0.
- A disabled port (srch_i[p]=0) registers vect 0, hit 0, idx 0.
- Write port w sets ram[addr]=data and valid[addr]=1.
- Two write ports targeting the same index: the higher-numbered port wins both data and valid.
- Update priority per entry, highest first: reset > flush_i > write > clear.
  - A write and a clear to the same entry in the same cycle leave the entry valid with the new data.
  - flush_i discards all same-cycle writes.
- validCnt_o is the popcount of the post-update valid vector, registered. Its range is 0..DEPTH inclusive, which is why it is INDEX+1 bits wide.

## Timing
- Search latency is 1 cycle: inputs presented in cycle N appear on vect_o/hit_o/idx_o in cycle N+1. Outputs hold until the next edge. Every port may search every cycle.
- A write in cycle N is searchable from cycle N+1, with result in N+2.
- validCnt_o in cycle N+1 reflects all updates made at the N edge.
- Reset (any cycle, including mid-search): at the next edge all valid bits become 0, and vect_o, hit_o, idx_o and validCnt_o become 0.
  - A search issued in the reset cycle returns zeros.
  - ram contents are retained but unreachable, because their valid bits are 0.
- Full (all valid) and empty states need no special handling. Writing an already valid entry overwrites it without changing the count.

## Test plan
- Reset, then search tag 0x00 with start 0 on both ports. Required: vect 0, hit 0, idx 0, validCnt_o 0, even though ram holds X/0.
- Write 0x5A to entries 3 and 9. Search 0x5A with start 5. One cycle later: vect 0x0208, hit 1, idx 3, validCnt_o 2.
- Wrap-around: write 0x5A to entries 9 and 12, then search with start 5. Required: idx 12 (scan 5…0, 15, 14, 13, 12), with entry 12 found before entry 9.
- Same-cycle events:
  - Port 0 writes 0x11 and port 1 writes 0x22 to entry 4, while clrVect_i bit 4 is set. Result: entry 4 valid with 0x22.
  - A search for 0x22 in that same cycle misses. The same search one cycle later hits idx 4.
- FUNCTION=1 instance: entries 0..3 hold 0x10, 0x20, 0x30, 0x40. Search tag 0x25 with start 3. Required: vect 0xC, idx 3.
- Fill all 16 entries: validCnt_o 16. Assert flush_i together with a write to entry 0: validCnt_o 0 and the next search misses. Then assert reset mid-stream: all outputs 0 at the next edge.
